// File: rtl/data_mem_responder_if.sv
// Load/store handshake bundle between the core's memory stage (master)
// and the data memory responder (slave).
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: accepts one load/store at a time,
// waits WAIT_CYCLES, performs the RAM access on the edge entering RESP and
// holds the response until the core takes it. Bad requests get rsp_err.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst,
  data_mem_if.slave bus,
  output logic      busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH];

  logic        a_write, a_uns, a_err, go_resp, we;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata, old_word;
  logic [AW-1:0] idx;

  // Pick the byte/half addressed by off, shift to bit 0 and extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    sb = 8'(word >> {off, 3'b000});
    sh = 16'(word >> {off[1], 4'b0000});
    case (size)
      2'b00:   r = uns ? 32'(unsigned'(sb)) : 32'(sb);
      2'b01:   r = uns ? 32'(unsigned'(sh)) : 32'(sh);
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte lanes of old with the low bits of wdata.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [3:0]  be;
    logic [31:0] wd, r;
    case (size)
      2'b00:   begin be = 4'b0001 << off;                 wd = {4{wdata[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011;     wd = {2{wdata[15:0]}}; end
      default: begin be = 4'b1111;                        wd = wdata;            end
    endcase
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Access operands: live inputs when the access happens on the accept edge
  // (WAIT_CYCLES = 0), otherwise the latched request.
  always_comb begin
    if (state_q == IDLE) begin
      a_write = bus.req_write;
      a_size  = bus.req_size;
      a_uns   = bus.req_unsigned;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
    end else begin
      a_write = write_q;
      a_size  = size_q;
      a_uns   = uns_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // Request legality: size, alignment and range.
  always_comb begin
    a_err = (a_size == 2'b11) ||
            (a_size == 2'b01 && a_addr[0]) ||
            (a_size == 2'b10 && a_addr[1:0] != 2'b00) ||
            ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
  end

  assign idx      = a_addr[AW+1:2];
  assign old_word = mem[idx];
  assign go_resp  = (state_q == IDLE && bus.req_valid && (WAIT_CYCLES == 0)) ||
                    (state_q == WAIT && cnt_q == 4'd0);
  assign we       = go_resp && a_write && !a_err && !rst;

  // Next-state, counter, request latch and response data.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      err_d   = a_err;
      rdata_d = (a_err || a_write) ? 32'd0 : load_extend(old_word, a_size, a_addr[1:0], a_uns);
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Latched request fields; only meaningful while a transaction is open.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // RAM write on the access edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= store_merge(old_word, a_wdata, a_size, a_addr[1:0]);
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one DUT with WAIT_CYCLES = 2 and
// one with WAIT_CYCLES = 0, driven through their interfaces.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic busy, busy0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  data_mem_if m ();
  data_mem_if m0 ();

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(m.slave), .busy(busy));
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(m0.slave), .busy(busy0));

  // One complete transaction on DUT sel (0: WAIT=2, 1: WAIT=0). lat counts
  // edges from the accept edge (inclusive) until rsp_valid is seen.
  task automatic do_req(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    if (sel) begin
      m0.req_valid = 1; m0.req_write = w; m0.req_size = sz; m0.req_unsigned = u;
      m0.req_addr = a; m0.req_wdata = d;
    end else begin
      m.req_valid = 1; m.req_write = w; m.req_size = sz; m.req_unsigned = u;
      m.req_addr = a; m.req_wdata = d;
    end
    @(posedge clk); #1;
    m.req_valid = 0; m0.req_valid = 0;
    lat = 1;
    while (!(sel ? m0.rsp_valid : m.rsp_valid) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    rd = sel ? m0.rsp_rdata : m.rsp_rdata;
    er = sel ? m0.rsp_err : m.rsp_err;
    m.rsp_ready = 1; m0.rsp_ready = 1;
    @(posedge clk); #1;
    m.rsp_ready = 0; m0.rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    m.req_valid = 0; m.req_write = 0; m.req_size = 0; m.req_unsigned = 0;
    m.req_addr = 0; m.req_wdata = 0; m.rsp_ready = 0;
    m0.req_valid = 0; m0.req_write = 0; m0.req_size = 0; m0.req_unsigned = 0;
    m0.req_addr = 0; m0.req_wdata = 0; m0.rsp_ready = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (m.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want=1", m.req_ready); end
    checks++; if (m.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", m.rsp_valid); end
    checks++; if (m.rsp_rdata !== 32'd0 || m.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_data got=%h/%b want=0/0", m.rsp_rdata, m.rsp_err); end
    checks++; if (busy !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b want=00", busy, busy0); end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_store_latency got=%0d want=3", lat); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL word_store_rsp got=%h/%b want=00000000/0", rd, er); end
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL word_load got=%h/%b want=deadbeef/0", rd, er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL word_load_latency got=%0d want=3", lat); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1, 2'b10, 0, 32'h20, 32'h11223344, rd, er, lat);
    do_req(0, 1, 2'b00, 0, 32'h21, 32'hFFFFFFAA, rd, er, lat);
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1122AA44) begin errors++; $display("FAIL lane_byte got=%h want=1122aa44", rd); end
    do_req(0, 1, 2'b01, 0, 32'h22, 32'hFFFF5566, rd, er, lat);
    do_req(0, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h5566AA44) begin errors++; $display("FAIL lane_half got=%h want=5566aa44", rd); end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] addr [6] = '{32'h31, 32'h32, 32'h33, 32'h32, 32'h32, 32'h33};
    logic [1:0]  sz   [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        un   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp  [6] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
                              32'hFFFF80FF, 32'h000080FF, 32'hFFFFFF80};
    do_req(0, 1, 2'b10, 0, 32'h30, 32'h80FF7F01, rd, er, lat);
    for (int i = 0; i < 6; i++) begin
      do_req(0, 0, sz[i], un[i], addr[i], 32'h0, rd, er, lat);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        errors++; $display("FAIL extend_%0d addr=%h got=%h/%b want=%h/0", i, addr[i], rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic        w  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [31:0] a  [5] = '{32'h11, 32'h13, 32'h10, 32'h400, 32'h400};
    do_req(0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      do_req(0, w[i], sz[i], 0, a[i], 32'h12345678, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0) begin
        errors++; $display("FAIL error_%0d addr=%h got=%h/%b want=00000000/1", i, a[i], rd, er);
      end
    end
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL error_untouched_10 got=%h want=deadbeef", rd); end
    do_req(0, 0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL error_untouched_00 got=%h want=cafef00d", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    m.req_valid = 1; m.req_write = 0; m.req_size = 2'b10; m.req_unsigned = 0; m.req_addr = 32'h10;
    @(posedge clk); #1;
    m.req_valid = 0;
    n = 0;
    while (!m.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (m.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_timeout got=%b want=1", m.rsp_valid); end
    m.req_valid = 1; m.req_write = 1; m.req_addr = 32'h10; m.req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (m.rsp_valid !== 1'b1 || m.rsp_rdata !== 32'hDEADBEEF || m.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got v=%b d=%h rdy=%b want v=1 d=deadbeef rdy=0", i, m.rsp_valid, m.rsp_rdata, m.req_ready);
      end
    end
    m.req_valid = 0; m.rsp_ready = 1;
    @(posedge clk); #1;
    m.rsp_ready = 0;
    checks++;
    if (m.rsp_valid !== 1'b0 || m.rsp_rdata !== 32'd0 || m.req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", m.rsp_valid, m.rsp_rdata, m.req_ready);
    end
    m.req_valid = 1; m.req_write = 0; m.req_size = 2'b10; m.req_addr = 32'h10;
    @(posedge clk); #1;
    m.req_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_next_accept got busy=%b want=1", busy); end
    n = 1;
    while (!m.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 3 || m.rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_next_rsp got lat=%0d d=%h want lat=3 d=deadbeef", n, m.rsp_rdata); end
    m.rsp_ready = 1;
    @(posedge clk); #1;
    m.rsp_ready = 0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int n;
    do_req(0, 1, 2'b10, 0, 32'h40, 32'h01020304, rd, er, lat);
    m.req_valid = 1; m.req_write = 1; m.req_size = 2'b10; m.req_addr = 32'h40; m.req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    m.req_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_wait got busy=%b want=1", busy); end
    rst = 1; #1;
    checks++;
    if ({m.req_ready, m.rsp_valid, m.rsp_err, busy} !== 4'b1000 || m.rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL abort_outputs got rdy/v/e/b=%b%b%b%b d=%h want 1000 d=0", m.req_ready, m.rsp_valid, m.rsp_err, busy, m.rsp_rdata);
    end
    repeat (2) @(posedge clk); #1;
    rst = 0;
    do_req(0, 0, 2'b10, 0, 32'h40, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL abort_no_write got=%h want=01020304", rd); end
    // reset while a load response is pending drops it
    m.req_valid = 1; m.req_write = 0; m.req_size = 2'b10; m.req_addr = 32'h40;
    @(posedge clk); #1;
    m.req_valid = 0;
    n = 0;
    while (!m.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checks++; if (m.rsp_rdata !== 32'h01020304) begin errors++; $display("FAIL resp_pending got=%h want=01020304", m.rsp_rdata); end
    rst = 1; #1;
    checks++;
    if (m.rsp_valid !== 1'b0 || m.rsp_rdata !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL resp_dropped got v=%b d=%h b=%b want 0/0/0", m.rsp_valid, m.rsp_rdata, busy);
    end
    @(posedge clk); #1;
    rst = 0;
    // reset while a store response is pending keeps the write
    m.req_valid = 1; m.req_write = 1; m.req_size = 2'b10; m.req_addr = 32'h44; m.req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    m.req_valid = 0;
    n = 0;
    while (!m.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    do_req(0, 0, 2'b10, 0, 32'h44, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL resp_write_persists got=%h want=55aa55aa", rd); end
  endtask

  task automatic test_wait0();
    logic [31:0] rd; logic er; int lat;
    do_req(1, 1, 2'b10, 0, 32'h50, 32'hA5A5A5A5, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b0) begin errors++; $display("FAIL wait0_store got lat=%0d err=%b want 1/0", lat, er); end
    do_req(1, 0, 2'b10, 0, 32'h50, 32'h0, rd, er, lat);
    checks++; if (lat !== 1 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL wait0_load got lat=%0d d=%h want 1/a5a5a5a5", lat, rd); end
    do_req(1, 0, 2'b00, 0, 32'h53, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFFA5) begin errors++; $display("FAIL wait0_sbyte got=%h want=ffffffa5", rd); end
    do_req(1, 0, 2'b01, 1, 32'h52, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000A5A5) begin errors++; $display("FAIL wait0_uhalf got=%h want=0000a5a5", rd); end
    do_req(1, 0, 2'b10, 0, 32'h52, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL wait0_misaligned got=%h/%b want=00000000/1", rd, er); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_extend();
    test_errors();
    test_backpressure();
    test_reset_abort();
    test_wait0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
